id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register. Sits directly downstream of the main control decoder.
- Captures the decoder's control bits (branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop) together with the decode-stage operands, and presents them to EX one cycle later.
- Contains the load-use hazard detector: produces the IF/ID stall and inserts bubbles.
- Handles branch flush and downstream hold.
- Keeps saturating bubble and flush counters for performance debug.

Parameters:
- XLEN, 32, data/PC/immediate width
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  control bits from the decoder
- id_aluop  in  2  ALU op class from the decoder
- id_pc  in  XLEN  PC of the decode instruction
- id_rs1_data, id_rs2_data  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
- id_funct3  in  3  funct3 field
- id_funct7_5  in  1  instruction bit 30
- ex_flush  in  1  branch taken in EX; kill the instruction entering EX
- hold_in  in  1  downstream stall; freeze the ID/EX register
- ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  registered
- ex_aluop  out  2  registered
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered
- ex_funct3  out  3  registered
- ex_funct7_5  out  1  registered
- stall_id  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt, flush_cnt  out  CNT_W each  registered saturating counters

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, including ex_valid and both counters. stall_id = 0 while in reset.
- Load-use hazard (combinational), all terms ANDed:
  - ex_valid
  - ex_memread
  - ex_rd != 0
  - id_valid
  - (id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)
- Per-edge priority:
  1. hold_in: all ex_* registers hold their value; counters hold; stall_id = 1. ex_flush and the hazard are ignored this cycle.
  2. ex_flush: load a bubble; flush_cnt += 1 if the ID instruction was valid; stall_id = 0.
  3. hazard: load a bubble; bubble_cnt += 1; stall_id = 1.
  4. Otherwise: load all id_* fields. ex_valid = id_valid. stall_id = 0.
- Bubble: ex_valid and all control outputs are 0 and aluop = 00. Data/index/funct outputs are also cleared to 0, so they can be checked deterministically.
- x0 suppression: when loading, ex_regwrite = id_regwrite & (id_rd != 0).
- Invalid input: when id_valid = 0, all control outputs load as 0 regardless of the id_* control inputs.
- Latency: exactly 1 cycle from ID to EX when not stalled.
- A hazard stall lasts exactly one cycle: next cycle EX holds a bubble (ex_memread = 0), so the hazard clears and the held instruction advances.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall clears all state immediately. stall_id drops in the same cycle, since ex_valid = 0.

Test Plan:
- Reset with rst_n = 0 while id_* are driven nonzero -> all ex_* = 0, stall_id = 0, counters = 0. After release, an id_valid ADDI (alusrc = 1, regwrite = 1, rd = 5, imm = 0x10) appears on ex_* at the next edge.
- LW x5 then ADD x6,x5,x7 (uses_rs1, rs1 = 5) -> stall_id = 1 for one cycle; EX shows a bubble (ex_valid = 0); ADD enters EX next cycle; bubble_cnt = 1.
- LW x0 followed by a consumer of x0 -> no stall. LW with rd = 5 followed by SW whose uses_rs2 = 0 and rs2 = 5 -> no stall.
- ex_flush = 1 coincident with a load-use hazard -> bubble loaded, stall_id = 0, flush_cnt = 1, bubble_cnt unchanged.
- hold_in = 1 for 3 cycles with changing id_* and ex_flush = 1 -> ex_* unchanged, stall_id = 1, counters unchanged. After release the flush takes effect.
- Force 2^CNT_W + 2 load-use hazards (CNT_W = 4 in the bench) -> bubble_cnt stays at 0xF and does not wrap.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush,
// downstream hold and saturating bubble/flush performance counters.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic            id_branch,
   input  logic            id_memread,
   input  logic            id_memtoreg,
   input  logic            id_memwrite,
   input  logic            id_alusrc,
   input  logic            id_regwrite,
   input  logic [1:0]      id_aluop,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic            id_uses_rs1,
   input  logic            id_uses_rs2,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7_5,
   input  logic            ex_flush,
   input  logic            hold_in,
   output logic            ex_valid,
   output logic            ex_branch,
   output logic            ex_memread,
   output logic            ex_memtoreg,
   output logic            ex_memwrite,
   output logic            ex_alusrc,
   output logic            ex_regwrite,
   output logic [1:0]      ex_aluop,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7_5,
   output logic            stall_id,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic hazard;
   logic bubble;

   // Saturating increment: an all-ones counter stays put instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Load-use detection against the load currently in EX, and the resulting stall.
   // stall_id is gated by rst_n so it reads 0 throughout reset even if hold_in is high.
   always_comb begin
      hazard   = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid &
                 ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
      bubble   = ex_flush | hazard;
      stall_id = rst_n & (hold_in | (~ex_flush & hazard));
   end

   // ID -> EX boundary: hold freezes everything, flush/hazard inject an all-zero
   // bubble, otherwise the decode instruction advances with its controls qualified.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_branch   <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_aluop    <= 2'b00;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= 5'd0;
         ex_rs2      <= 5'd0;
         ex_rd       <= 5'd0;
         ex_funct3   <= 3'd0;
         ex_funct7_5 <= 1'b0;
      end else if (!hold_in) begin
         if (bubble) begin
            ex_valid    <= 1'b0;
            ex_branch   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct3   <= 3'd0;
            ex_funct7_5 <= 1'b0;
         end else begin
            ex_valid    <= id_valid;
            ex_branch   <= id_valid & id_branch;
            ex_memread  <= id_valid & id_memread;
            ex_memtoreg <= id_valid & id_memtoreg;
            ex_memwrite <= id_valid & id_memwrite;
            ex_alusrc   <= id_valid & id_alusrc;
            // Writes to x0 are dropped here so later stages never see them.
            ex_regwrite <= id_valid & id_regwrite & (id_rd != 5'd0);
            ex_aluop    <= id_aluop & {2{id_valid}};
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_funct7_5 <= id_funct7_5;
         end
      end
   end

   // Performance counters: flushes of real instructions and load-use bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else if (!hold_in) begin
         if (ex_flush) begin
            if (id_valid) flush_cnt <= sat_inc(flush_cnt);
         end else if (hazard) begin
            bubble_cnt <= sat_inc(bubble_cnt);
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model predicts the EX
// register contents and counters each cycle; predictions are queued and
// compared against the DUT one edge later.
module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic valid, branch, memread, memtoreg, memwrite, alusrc, regwrite;
      logic [1:0] aluop;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0] rs1, rs2, rd;
      logic urs1, urs2;
      logic [2:0] funct3;
      logic f75;
   } in_t;

   typedef struct packed {
      logic valid, branch, memread, memtoreg, memwrite, alusrc, regwrite;
      logic [1:0] aluop;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0] rs1, rs2, rd;
      logic [2:0] funct3;
      logic f75;
   } ex_t;

   typedef struct packed {
      ex_t e;
      logic [CNT_W-1:0] bc, fc;
   } exp_t;

   logic clk, rst_n;
   logic id_valid, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
   logic [1:0] id_aluop;
   logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic id_uses_rs1, id_uses_rs2;
   logic [2:0] id_funct3;
   logic id_funct7_5, ex_flush, hold_in;
   logic ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
   logic [1:0] ex_aluop;
   logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic [2:0] ex_funct3;
   logic ex_funct7_5, stall_id;
   logic [CNT_W-1:0] bubble_cnt, flush_cnt;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_branch(id_branch), .id_memread(id_memread),
      .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
      .id_regwrite(id_regwrite), .id_aluop(id_aluop), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
      .ex_flush(ex_flush), .hold_in(hold_in),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_memread(ex_memread),
      .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
      .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
      .stall_id(stall_id), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   ex_t obs;
   assign obs = {ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc,
                 ex_regwrite, ex_aluop, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                 ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_5};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   nvec = 0;
   int   nmis = 0;
   exp_t sbq[$];
   ex_t  m;
   logic [CNT_W-1:0] mbc, mfc;

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
      if (c == {CNT_W{1'b1}}) return c;
      return c + 1;
   endfunction

   function automatic ex_t load(input in_t i);
      ex_t e;
      e.valid    = i.valid;
      e.branch   = i.valid & i.branch;
      e.memread  = i.valid & i.memread;
      e.memtoreg = i.valid & i.memtoreg;
      e.memwrite = i.valid & i.memwrite;
      e.alusrc   = i.valid & i.alusrc;
      e.regwrite = i.valid & i.regwrite & (i.rd != 0);
      e.aluop    = i.valid ? i.aluop : 2'b00;
      e.pc = i.pc; e.rs1d = i.rs1d; e.rs2d = i.rs2d; e.imm = i.imm;
      e.rs1 = i.rs1; e.rs2 = i.rs2; e.rd = i.rd;
      e.funct3 = i.funct3; e.f75 = i.f75;
      return e;
   endfunction

   function automatic in_t mk(input logic mr, mw, as, rw, input logic [1:0] op,
                              input logic [4:0] rd, rs1, rs2, input logic u1, u2);
      in_t i;
      i.valid = 1'b1; i.branch = 1'b0; i.memread = mr; i.memtoreg = mr;
      i.memwrite = mw; i.alusrc = as; i.regwrite = rw; i.aluop = op;
      i.pc = $urandom; i.rs1d = $urandom; i.rs2d = $urandom; i.imm = $urandom;
      i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.urs1 = u1; i.urs2 = u2;
      i.funct3 = 3'($urandom_range(0, 7)); i.f75 = 1'($urandom_range(0, 1));
      return i;
   endfunction

   function automatic in_t lw(input logic [4:0] rd);
      return mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, rd, 5'd2, 5'd0, 1'b1, 1'b0);
   endfunction

   function automatic in_t add(input logic [4:0] rd, rs1, rs2);
      return mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, rd, rs1, rs2, 1'b1, 1'b1);
   endfunction

   function automatic in_t addi(input logic [4:0] rd);
      in_t i;
      i = mk(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, rd, 5'd1, 5'd0, 1'b1, 1'b0);
      i.imm = 32'h10;
      return i;
   endfunction

   task automatic apply(input in_t i);
      id_valid = i.valid; id_branch = i.branch; id_memread = i.memread;
      id_memtoreg = i.memtoreg; id_memwrite = i.memwrite; id_alusrc = i.alusrc;
      id_regwrite = i.regwrite; id_aluop = i.aluop; id_pc = i.pc;
      id_rs1_data = i.rs1d; id_rs2_data = i.rs2d; id_imm = i.imm;
      id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
      id_uses_rs1 = i.urs1; id_uses_rs2 = i.urs2;
      id_funct3 = i.funct3; id_funct7_5 = i.f75;
   endtask

   // One clock of stimulus: predict, queue, clock, pop and compare.
   task automatic step(input in_t i, input logic fl, input logic hl);
      logic haz, stl;
      exp_t x;
      apply(i);
      ex_flush = fl;
      hold_in  = hl;
      #1;
      haz = m.valid & m.memread & (m.rd != 0) & i.valid &
            ((i.urs1 & (i.rs1 == m.rd)) | (i.urs2 & (i.rs2 == m.rd)));
      stl = hl | (~fl & haz);
      chk("stall_id", 160'(stall_id), 160'(stl));
      if (!hl) begin
         if (fl) begin
            m = '0;
            if (i.valid) mfc = sat(mfc);
         end else if (haz) begin
            m = '0;
            mbc = sat(mbc);
         end else begin
            m = load(i);
         end
      end
      x.e = m; x.bc = mbc; x.fc = mfc;
      sbq.push_back(x);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 160'(1), 160'(0));
      end else begin
         x = sbq.pop_front();
         chk("ex_regs", 160'(obs), 160'(x.e));
         chk("bubble_cnt", 160'(bubble_cnt), 160'(x.bc));
         chk("flush_cnt", 160'(flush_cnt), 160'(x.fc));
      end
   endtask

   initial begin
      in_t t;
      m = '0; mbc = '0; mfc = '0;
      rst_n = 1'b0;
      apply(addi(5'd5));
      ex_flush = 1'b0;
      hold_in  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ex_regs", 160'(obs), 160'(0));
      chk("rst_stall", 160'(stall_id), 160'(0));
      chk("rst_bubble_cnt", 160'(bubble_cnt), 160'(0));
      chk("rst_flush_cnt", 160'(flush_cnt), 160'(0));
      hold_in = 1'b0;
      rst_n   = 1'b1;

      // First instruction after reset: ADDI x5, imm 0x10.
      step(addi(5'd5), 1'b0, 1'b0);
      chk("addi_imm", 160'(ex_imm), 160'(32'h10));
      chk("addi_rd", 160'(ex_rd), 160'(5));

      // Load-use: LW x5 then ADD x6,x5,x7 stalls one cycle.
      step(lw(5'd5), 1'b0, 1'b0);
      t = add(5'd6, 5'd5, 5'd7);
      step(t, 1'b0, 1'b0);
      chk("luse_bubble_valid", 160'(ex_valid), 160'(0));
      step(t, 1'b0, 1'b0);
      chk("luse_add_rd", 160'(ex_rd), 160'(6));
      chk("luse_bubble_cnt", 160'(bubble_cnt), 160'(1));

      // LW x0 followed by a consumer of x0: no stall.
      step(lw(5'd0), 1'b0, 1'b0);
      chk("lw_x0_regwrite", 160'(ex_regwrite), 160'(0));
      step(add(5'd8, 5'd0, 5'd0), 1'b0, 1'b0);
      // LW x5 then SW with rs2 = 5 not used: no stall.
      step(lw(5'd5), 1'b0, 1'b0);
      step(mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 5'd3, 5'd5, 1'b1, 1'b0), 1'b0, 1'b0);

      // Flush coincident with a load-use hazard.
      step(lw(5'd5), 1'b0, 1'b0);
      step(add(5'd6, 5'd5, 5'd7), 1'b1, 1'b0);
      chk("flush_cnt_one", 160'(flush_cnt), 160'(1));
      chk("flush_bubble_cnt", 160'(bubble_cnt), 160'(1));

      // Hold for 3 cycles with flush and changing inputs, then release.
      step(lw(5'd5), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(add(5'(k + 10), 5'd5, 5'd5), 1'b1, 1'b1);
      chk("hold_memread", 160'(ex_memread), 160'(1));
      step(add(5'd9, 5'd5, 5'd5), 1'b1, 1'b0);
      chk("hold_release_flush", 160'(flush_cnt), 160'(2));

      // Invalid decode slot: controls cleared, data still loads.
      t = add(5'd9, 5'd1, 5'd2);
      t.valid = 1'b0; t.branch = 1'b1;
      step(t, 1'b0, 1'b0);
      step(addi(5'd0), 1'b0, 1'b0);

      // Saturate the bubble counter: 2^CNT_W + 2 load-use hazards.
      for (int k = 0; k < (1 << CNT_W) + 2; k++) begin
         step(lw(5'd4), 1'b0, 1'b0);
         t = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd7, 5'd1, 5'd4, 1'b0, 1'b1);
         step(t, 1'b0, 1'b0);
         step(t, 1'b0, 1'b0);
      end
      chk("bubble_cnt_sat", 160'(bubble_cnt), 160'(4'hF));

      // Reset asserted mid-stall clears state and drops stall_id at once.
      step(lw(5'd5), 1'b0, 1'b0);
      apply(add(5'd6, 5'd5, 5'd5));
      #1;
      chk("midstall_stall", 160'(stall_id), 160'(1));
      rst_n = 1'b0;
      #1;
      chk("midrst_stall", 160'(stall_id), 160'(0));
      chk("midrst_ex_regs", 160'(obs), 160'(0));
      chk("midrst_cnts", 160'({bubble_cnt, flush_cnt}), 160'(0));
      m = '0; mbc = '0; mfc = '0;
      #1;
      rst_n = 1'b1;
      step(addi(5'd3), 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
